// File: rtl/serial_sram_pkg.sv
// Shared opcodes, FSM state encoding and width helper for the serial SRAM command processor.
package serial_sram_pkg;

    typedef enum logic [2:0] {
        StRx,
        StExec,
        StRamReq,
        StRamWait,
        StTxSend,
        StTxWait
    } state_t;

    localparam logic [7:0] CmdAddr    = 8'h01;
    localparam logic [7:0] CmdLoad    = 8'h02;
    localparam logic [7:0] CmdWrite   = 8'h03;
    localparam logic [7:0] CmdRead    = 8'h04;
    localparam logic [7:0] CmdReadReq = 8'h05;
    localparam logic [7:0] CmdCount   = 8'h06;
    localparam logic [7:0] CmdFill    = 8'h08;
    localparam logic [7:0] CmdSum     = 8'h09;
    localparam logic [7:0] CmdMode    = 8'h0A;
    localparam logic [7:0] CmdStatus  = 8'h0B;

    // Argument and reply payloads are both ARG_BYTES wide.
    function automatic int unsigned arg_width(input int unsigned arg_bytes);
        return 8 * arg_bytes;
    endfunction

endpackage

// File: rtl/serial_sram_ctrl_frame_rx.sv
// Assembles command frames (cmd byte + argument bytes, MSB first) and discards
// partial frames after an idle timeout.
module serial_sram_ctrl_frame_rx
    import serial_sram_pkg::*;
#(
    parameter int unsigned ARG_BYTES = 4,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              accept,
    output logic                              frame_done,
    output logic [7:0]                        cmd,
    output logic [arg_width(ARG_BYTES)-1:0]   arg,
    output logic                              drop
);

    localparam int unsigned ArgW   = arg_width(ARG_BYTES);
    localparam int unsigned FrameW = ArgW + 8;
    localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);

    logic [FrameW-1:0] frame_q, frame_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [IdleW-1:0]  idle_q, idle_d;

    always_comb begin
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        frame_done = 1'b0;
        if (accept && rx_valid) begin
            frame_d = {frame_q[FrameW-9:0], rx_data};
            idle_d  = '0;
            if (cnt_q == 3'(ARG_BYTES)) begin
                cnt_d      = '0;
                frame_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (accept && cnt_q != 3'd0) begin
            if (idle_q == IdleW'(TIMEOUT - 1)) begin
                cnt_d  = '0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_q <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

    // The frame register only shifts while accepting, so it holds the
    // complete frame for the whole execution.
    assign cmd  = frame_q[FrameW-1 -: 8];
    assign arg  = frame_q[ArgW-1:0];
    assign drop = rx_valid && !accept;

endmodule

// File: rtl/serial_sram_ctrl.sv
// Serial command processor: executes framed commands against an SRAM driver and
// returns a fixed-length big-endian reply per frame.
module serial_sram_ctrl
    import serial_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ARG_BYTES = 4,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready,
    output logic              ram_start,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_write,
    input  logic [DATA_W-1:0] ram_data_read,
    input  logic              ram_ready,
    output logic [DATA_W-1:0] last_read,
    output logic              busy
);

    localparam int unsigned ArgW = arg_width(ARG_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] last_read_q, last_read_d;
    logic [ArgW-1:0]   count_q, count_d;
    logic [ArgW-1:0]   reply_q, reply_d;
    logic [ArgW-1:0]   rem_q, rem_d;
    logic [ArgW-1:0]   sum_q, sum_d;
    logic              autoinc_q, autoinc_d;
    logic              overrun_q, overrun_d;
    logic              ram_start_q, ram_start_d;
    logic              ram_re_q, ram_re_d;
    logic              burst_q, burst_d;
    logic              tx_low_q, tx_low_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;

    logic              accept;
    logic              frame_done;
    logic              drop;
    logic [7:0]        cmd;
    logic [ArgW-1:0]   arg;

    assign accept = (state_q == StRx);

    serial_sram_ctrl_frame_rx #(
        .ARG_BYTES (ARG_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) u_frame_rx (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .accept     (accept),
        .frame_done (frame_done),
        .cmd        (cmd),
        .arg        (arg),
        .drop       (drop)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_read_d = last_read_q;
        count_d     = count_q;
        reply_d     = reply_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        autoinc_d   = autoinc_q;
        overrun_d   = overrun_q | drop;
        ram_start_d = ram_start_q;
        ram_re_d    = ram_re_q;
        burst_d     = burst_q;
        tx_low_d    = tx_low_q;
        tx_cnt_d    = tx_cnt_q;
        tx_start    = 1'b0;

        unique case (state_q)
            StRx: begin
                if (frame_done) state_d = StExec;
            end
            StExec: begin
                state_d  = StTxSend;
                tx_cnt_d = '0;
                case (cmd)
                    CmdAddr: begin
                        addr_d  = arg[ADDR_W-1:0];
                        reply_d = arg;
                    end
                    CmdLoad: begin
                        wdata_d = arg[DATA_W-1:0];
                        reply_d = arg;
                    end
                    CmdWrite, CmdReadReq: begin
                        ram_re_d = (cmd == CmdReadReq);
                        burst_d  = 1'b0;
                        rem_d    = ArgW'(1);
                        state_d  = StRamReq;
                    end
                    CmdRead: reply_d = ArgW'(last_read_q);
                    CmdCount: begin
                        reply_d = count_q;
                        count_d = count_q + ArgW'(1);
                    end
                    CmdFill, CmdSum: begin
                        // Fill replies with N; Sum's reply is replaced on completion.
                        reply_d = (cmd == CmdFill) ? arg : '0;
                        sum_d   = '0;
                        if (arg != '0) begin
                            ram_re_d = (cmd == CmdSum);
                            burst_d  = 1'b1;
                            rem_d    = arg;
                            state_d  = StRamReq;
                        end
                    end
                    CmdMode: begin
                        autoinc_d = arg[0];
                        reply_d   = ArgW'(arg[0]);
                    end
                    CmdStatus: begin
                        reply_d   = ArgW'({autoinc_q, overrun_q});
                        overrun_d = drop;
                    end
                    default: reply_d = ArgW'(cmd);
                endcase
            end
            StRamReq: begin
                if (!ram_start_q) begin
                    if (ram_ready) ram_start_d = 1'b1;
                end else if (!ram_ready) begin
                    ram_start_d = 1'b0;
                    state_d     = StRamWait;
                end
            end
            StRamWait: begin
                if (ram_ready) begin
                    if (ram_re_q) begin
                        last_read_d = ram_data_read;
                        sum_d       = sum_q + ArgW'(ram_data_read);
                    end
                    if (burst_q || autoinc_q) addr_d = addr_q + ADDR_W'(1);
                    rem_d = rem_q - ArgW'(1);
                    if (rem_q == ArgW'(1)) begin
                        state_d = StTxSend;
                        if (!burst_q) begin
                            reply_d = ArgW'(cmd);
                        end else if (ram_re_q) begin
                            reply_d = sum_d;
                        end
                    end else begin
                        state_d = StRamReq;
                    end
                end
            end
            StTxSend: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_low_d = 1'b0;
                    state_d  = StTxWait;
                end
            end
            StTxWait: begin
                // Byte is done only after the UART has gone busy and idle again.
                if (!tx_ready) begin
                    tx_low_d = 1'b1;
                end else if (tx_low_q) begin
                    reply_d  = reply_q << 8;
                    tx_cnt_d = tx_cnt_q + 3'd1;
                    state_d  = (tx_cnt_q == 3'(ARG_BYTES - 1)) ? StRx : StTxSend;
                end
            end
            default: state_d = StRx;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StRx;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_read_q <= '0;
            count_q     <= '0;
            reply_q     <= '0;
            rem_q       <= '0;
            sum_q       <= '0;
            autoinc_q   <= 1'b0;
            overrun_q   <= 1'b0;
            ram_start_q <= 1'b0;
            ram_re_q    <= 1'b0;
            burst_q     <= 1'b0;
            tx_low_q    <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_read_q <= last_read_d;
            count_q     <= count_d;
            reply_q     <= reply_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            autoinc_q   <= autoinc_d;
            overrun_q   <= overrun_d;
            ram_start_q <= ram_start_d;
            ram_re_q    <= ram_re_d;
            burst_q     <= burst_d;
            tx_low_q    <= tx_low_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign tx_data        = reply_q[ArgW-1 -: 8];
    assign ram_start      = ram_start_q;
    assign ram_re         = ram_re_q;
    assign ram_address    = addr_q;
    assign ram_data_write = wdata_q;
    assign last_read      = last_read_q;
    assign busy           = (state_q != StRx);

endmodule

// File: doc/serial_sram_ctrl.md
Name: serial_sram_ctrl

Overview:
Parametrised serial command processor that sits between the UART pair (uart_rx/uart_tx) and sram_driver. It assembles fixed-length command frames from the byte stream and executes single or burst SRAM accesses with an address auto-increment mode. It returns a fixed-length big-endian reply per frame, replacing the ad-hoc top-level command logic.

Parameters:
ADDR_W, 13, SRAM address width; address arithmetic wraps modulo 2^ADDR_W
DATA_W, 8, SRAM data width (1..8*ARG_BYTES)
ARG_BYTES, 4, argument bytes per frame and reply bytes per frame (1..4)
TIMEOUT, 50000, idle clk cycles after which a partial frame is discarded

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx rcv)
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit strobe
tx_ready  in  1  UART idle; falls 1-2 cycles after tx_start
ram_start  out  1  access request to sram_driver
ram_re  out  1  1=read, 0=write; stable while ram_start high
ram_address  out  ADDR_W  access address
ram_data_write  out  DATA_W  write data (LOAD register)
ram_data_read  in  DATA_W  read data, valid when ram_ready rises
ram_ready  in  1  driver idle/done
last_read  out  DATA_W  last captured read data (LEDs)
busy  out  1  high outside S_RX

Behaviour:
- Reset: all outputs 0; addr, wdata, count, autoinc, overrun, byte counter 0; state S_RX.
- Frame: 1 cmd byte + ARG_BYTES argument bytes, MSB first; the frame executes the cycle after its last byte is received (S_RX -> S_EXEC).
- Timeout: in S_RX with 0 < byte count, TIMEOUT cycles without rx_valid -> byte count to 0, partial frame dropped, no reply.
- rx_valid outside S_RX: byte dropped, overrun sticky set.
- Commands (arg = frame argument; reply zero-extended to ARG_BYTES):
  - 0x01 ADDR: addr <= arg[ADDR_W-1:0]; reply arg.
  - 0x02 LOAD: wdata <= arg[DATA_W-1:0]; reply arg.
  - 0x03 WRITE: one write at addr; reply 0x03 after completion.
  - 0x04 READ: reply last_read; no RAM access.
  - 0x05 READ_REQ: one read at addr; last_read captured; reply 0x05 after completion.
  - For 0x03 and 0x05: if autoinc=1, addr increments after the access.
  - 0x06 COUNT: reply count; then count+1, wraps at 2^(8*ARG_BYTES).
  - 0x08 FILL: write wdata to N=arg locations from addr, addr+1 each; reply N. N=0 -> no access, reply 0.
  - 0x09 SUM: read N locations from addr, addr+1 each; reply sum of data mod 2^(8*ARG_BYTES); last_read = final word.
  - 0x0A MODE: autoinc <= arg[0]; reply arg[0].
  - 0x0B STATUS: reply {autoinc,overrun} in bits[1:0]; overrun cleared by this read. A drop in the same cycle keeps it set.
  - Other: reply cmd byte.
- After a burst (FILL/SUM), addr = start+N mod 2^ADDR_W, regardless of autoinc.
- RAM handshake: S_RAM_REQ waits ram_ready=1, then raises ram_start. ram_start stays high until ram_ready is seen 0, then drops (S_RAM_WAIT). Completion = ram_ready back to 1; read data is captured in that cycle.
- TX handshake: per byte, wait tx_ready=1, then pulse tx_start 1 cycle with the byte. Then wait for tx_ready=0, then tx_ready=1 before the next byte. Exactly ARG_BYTES bytes per frame.
- States: S_RX, S_EXEC, S_RAM_REQ, S_RAM_WAIT, S_TX_SEND, S_TX_WAIT; S_TX_WAIT after last byte -> S_RX.
- Reset mid-operation: immediate return to reset values; in-flight access abandoned, ram_start=0.

Decomposition:
- Package serial_sram_pkg: command opcode constants, state encoding, reply/arg width function.
- Sub-module frame_rx: byte assembly, counter, timeout.
- Execution/TX FSM stays in serial_sram_ctrl.

Test Plan:
- Defaults, ideal driver (ready low 3 cycles per access): frames 01 00000010, 02 000000A5, 03 00000000, 05 00000000, 04 00000000 -> replies 00000010, 000000A5, 00000003, 00000005, 000000A5; one write then one read at 0x10.
- MODE 1, ADDR 0x1FFF, WRITE twice -> writes at 0x1FFF then 0x0000; addr ends 0x0001.
- FILL 4 with wdata 0x11 at 0x100, then ADDR 0x100, SUM 4 -> reply 00000004, then 00000044. FILL 0 -> reply 0, no ram_start.
- Send 3 bytes then idle TIMEOUT+1 cycles, then full COUNT frame -> no reply for the fragment; reply 00000000; next COUNT -> 00000001.
- Byte sent during a 255-word FILL -> dropped; STATUS -> 00000001, second STATUS -> 00000000.
- rstn low during S_RAM_WAIT -> ram_start=0, busy=0, state S_RX; next ADDR frame executes normally.
